// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences byte or word memory accesses, with a wait-state timeout.
// Optional macro MEM_WORD_READ_EN enables 16-bit little-endian word reads (HI beat).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module mem_access_ctrl #(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   addr_in,
    input  logic [DATA_WIDTH-1:0]   wdata_in,
    input  logic                    req,
    input  logic                    we,
    input  logic                    word,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [2*DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic                    mem_en,
    output logic                    mem_we,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ready
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          we_q;
    logic          word_eff;
    logic          timed_out;

`ifdef MEM_WORD_READ_EN
    logic          word_q;
    // Word reads only make sense for reads; a word write is a plain byte write.
    assign word_eff = word & ~we;
`else
    // Without word support the port is tied off inside the block.
    assign word_eff = word & 1'b0;
`endif

    // Timeout fires on the last allowed wait cycle of a beat.
    assign timed_out = (TIMEOUT != 0) && (cnt == TO_LAST) && !mem_ready;
    assign busy = (state != IDLE);

    // Access sequencer: latches the request and drives the memory-side beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
`ifdef MEM_WORD_READ_EN
            word_q    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        mem_addr  <= addr_in;
                        mem_wdata <= wdata_in;
                        we_q      <= we;
                        cnt       <= '0;
                        mem_en    <= 1'b1;
                        mem_we    <= we;
                        state     <= LO;
`ifdef MEM_WORD_READ_EN
                        word_q    <= word_eff;
                        if (!we) rdata[2*DATA_WIDTH-1:DATA_WIDTH] <= '0;
`endif
                    end
                end
                LO: begin
                    if (mem_ready) begin
                        cnt <= '0;
                        if (!we_q) rdata[DATA_WIDTH-1:0] <= mem_rdata;
`ifdef MEM_WORD_READ_EN
                        if (word_q) begin
                            mem_addr <= mem_addr + 1'b1;
                            mem_we   <= 1'b0;
                            state    <= HI;
                        end else begin
                            done   <= 1'b1;
                            mem_en <= 1'b0;
                            mem_we <= 1'b0;
                            state  <= DONE;
                        end
`else
                        done   <= 1'b1;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        state  <= DONE;
`endif
                    end else if (timed_out) begin
                        cnt    <= '0;
                        done   <= 1'b1;
                        err    <= 1'b1;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef MEM_WORD_READ_EN
                HI: begin
                    if (mem_ready || timed_out) begin
                        if (mem_ready) begin
                            rdata[2*DATA_WIDTH-1:DATA_WIDTH] <= mem_rdata;
                        end
                        cnt    <= '0;
                        done   <= 1'b1;
                        err    <= !mem_ready;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
